// File: rtl/bp_pkg.sv
// Shared definitions for the branch-predictor history controller.
//   ghr_t           : global history at the default width
//   bp_hist_state_e : history controller FSM states
//   STAT_W          : width of the optional statistics counters
package bp_pkg;

  localparam int unsigned GHR_W_DEF = 4;
  localparam int unsigned STAT_W    = 16;

  typedef logic [GHR_W_DEF-1:0] ghr_t;

  typedef enum logic [0:0] {
    NORMAL  = 1'b0,
    RECOVER = 1'b1
  } bp_hist_state_e;

endpackage

// File: rtl/bp_ckpt_fifo.sv
// Checkpoint FIFO: one history snapshot per in-flight predicted branch.
//   clk_i, rst_ni  : clock, asynchronous active-low reset
//   clear_i        : empty the FIFO (wins over push/pop)
//   push_i/_data_i : store a snapshot at the tail (caller guarantees !full)
//   pop_i          : drop the head entry (caller guarantees !empty)
//   head_data_o    : snapshot at the head
//   tail_idx_o     : slot the next push will use
//   full_o/empty_o : occupancy flags
module bp_ckpt_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 4,
  localparam int unsigned PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_data_o,
  output logic [PTR_W-1:0] tail_idx_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, tail_q;
  logic [PTR_W:0]   count_q, count_d;

  always_comb begin
    count_d = count_q;
    unique case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q   <= '{default: '0};
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[tail_q] <= push_data_i;
        tail_q        <= tail_q + 1'b1;
      end
      if (pop_i) begin
        head_q <= head_q + 1'b1;
      end
      count_q <= count_d;
    end
  end

  assign head_data_o = mem_q[head_q];
  assign tail_idx_o  = tail_q;
  assign full_o      = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o     = (count_q == '0);

endmodule

// File: rtl/bp_history_ctrl.sv
// Speculative / architectural global-history controller.
//   clk_i, rst_ni        : clock, asynchronous active-low reset
//   pred_*               : fetch-side prediction handshake; pred_tag_o is the assigned slot
//   spec_ghr_o           : speculative history for PHT indexing
//   resolve_*            : in-order branch resolution; resolve_ghr_o is the head checkpoint
//   commit_ghr_o         : architectural history
//   flush_i              : external pipeline flush
//   recovering_o         : one-cycle recovery after mispredict/flush
// Optional (BP_HISTORY_CTRL_STATS_EN): stat_preds_o, stat_mispreds_o saturating counters.
module bp_history_ctrl import bp_pkg::*; #(
  parameter int unsigned GHR_W = 4,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     pred_valid_i,
  input  logic                     pred_taken_i,
  output logic                     pred_ready_o,
  output logic [$clog2(DEPTH)-1:0] pred_tag_o,
  output logic [GHR_W-1:0]         spec_ghr_o,
  input  logic                     resolve_valid_i,
  input  logic                     resolve_taken_i,
  input  logic                     resolve_mispredict_i,
  output logic [GHR_W-1:0]         resolve_ghr_o,
  output logic [GHR_W-1:0]         commit_ghr_o,
  input  logic                     flush_i,
  output logic                     recovering_o
`ifdef BP_HISTORY_CTRL_STATS_EN
  ,
  output logic [STAT_W-1:0]        stat_preds_o,
  output logic [STAT_W-1:0]        stat_mispreds_o
`endif
);

  function automatic logic [GHR_W-1:0] shift_in(input logic [GHR_W-1:0] h, input logic b);
    return {h[GHR_W-2:0], b};
  endfunction

  bp_hist_state_e   state_q, state_d;
  logic [GHR_W-1:0] spec_q, spec_d;
  logic [GHR_W-1:0] commit_q, commit_d;
  logic             fifo_full, fifo_empty;
  logic             accept, res_fire, mispredict, correct, restore;

  // A resolve against an empty FIFO (e.g. during recovery) has nothing to retire.
  assign res_fire   = resolve_valid_i && !fifo_empty;
  assign mispredict = res_fire && resolve_mispredict_i;
  assign correct    = res_fire && !resolve_mispredict_i;
  assign restore    = mispredict || flush_i;
  assign accept     = pred_valid_i && pred_ready_o;

  bp_ckpt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (GHR_W)
  ) u_ckpt_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clear_i     (restore),
    .push_i      (accept),
    .push_data_i (spec_q),
    .pop_i       (correct),
    .head_data_o (resolve_ghr_o),
    .tail_idx_o  (pred_tag_o),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  // History next-state: the commit update lands first so a restore sees it.
  always_comb begin
    commit_d = commit_q;
    spec_d   = spec_q;
    if (res_fire) begin
      commit_d = shift_in(commit_q, resolve_taken_i);
    end
    if (restore) begin
      spec_d = commit_d;
    end else if (accept) begin
      spec_d = shift_in(spec_q, pred_taken_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      spec_q   <= '0;
      commit_q <= '0;
    end else begin
      spec_q   <= spec_d;
      commit_q <= commit_d;
    end
  end

  // FSM state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= NORMAL;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      NORMAL:  if (restore) state_d = RECOVER;
      RECOVER: state_d = NORMAL;
      default: state_d = NORMAL;
    endcase
  end

  // FSM outputs; ready uses the raw mispredict flag to stay off timing-heavy paths.
  always_comb begin
    recovering_o = (state_q == RECOVER);
    pred_ready_o = (state_q == NORMAL) && !fifo_full && !flush_i &&
                   !(resolve_valid_i && resolve_mispredict_i);
  end

  assign spec_ghr_o   = spec_q;
  assign commit_ghr_o = commit_q;

`ifdef BP_HISTORY_CTRL_STATS_EN
  logic [STAT_W-1:0] stat_preds_q, stat_mispreds_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_preds_q    <= '0;
      stat_mispreds_q <= '0;
    end else begin
      if (accept && (stat_preds_q != '1)) begin
        stat_preds_q <= stat_preds_q + 1'b1;
      end
      if (mispredict && (stat_mispreds_q != '1)) begin
        stat_mispreds_q <= stat_mispreds_q + 1'b1;
      end
    end
  end

  assign stat_preds_o    = stat_preds_q;
  assign stat_mispreds_o = stat_mispreds_q;
`endif

endmodule

// File: tb/tb_bp_history_ctrl.sv
module tb_bp_history_ctrl;

  localparam int GHR_W = 4;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       pred_valid, pred_taken, pred_ready;
  logic [1:0] pred_tag;
  logic [3:0] spec_ghr, resolve_ghr, commit_ghr;
  logic       resolve_valid, resolve_taken, resolve_mispredict;
  logic       flush, recovering;
`ifdef BP_HISTORY_CTRL_STATS_EN
  logic [15:0] stat_preds, stat_mispreds;
`endif

  always #5 clk = ~clk;

  bp_history_ctrl #(
    .GHR_W (GHR_W),
    .DEPTH (DEPTH)
  ) dut (
    .clk_i                (clk),
    .rst_ni               (rst_ni),
    .pred_valid_i         (pred_valid),
    .pred_taken_i         (pred_taken),
    .pred_ready_o         (pred_ready),
    .pred_tag_o           (pred_tag),
    .spec_ghr_o           (spec_ghr),
    .resolve_valid_i      (resolve_valid),
    .resolve_taken_i      (resolve_taken),
    .resolve_mispredict_i (resolve_mispredict),
    .resolve_ghr_o        (resolve_ghr),
    .commit_ghr_o         (commit_ghr),
    .flush_i              (flush),
    .recovering_o         (recovering)
`ifdef BP_HISTORY_CTRL_STATS_EN
    ,
    .stat_preds_o         (stat_preds),
    .stat_mispreds_o      (stat_mispreds)
`endif
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: a queue of checkpoints plus the two histories.
  int q[$];
  int spec_m, commit_m, head_m, sp_m, sm_m;
  bit rec_m;
  bit last_ready;
  int last_tag;

  function automatic int shf(input int h, input bit b);
    return ((h << 1) | int'(b)) & ((1 << GHR_W) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    spec_m = 0; commit_m = 0; head_m = 0; sp_m = 0; sm_m = 0; rec_m = 0;
  endtask

  task automatic idle();
    pred_valid = 0; pred_taken = 0; resolve_valid = 0;
    resolve_taken = 0; resolve_mispredict = 0; flush = 0;
  endtask

  // One clock: drive, check combinational/registered outputs at negedge, advance model.
  task automatic cycle(input bit pv, input bit pt, input bit rv, input bit rt,
                       input bit rm, input bit fl);
    bit rdy, acc, fire, mis;
    pred_valid = pv; pred_taken = pt; resolve_valid = rv;
    resolve_taken = rt; resolve_mispredict = rm; flush = fl;
    @(negedge clk);
    rdy = !rec_m && (q.size() < DEPTH) && !fl && !(rv && rm);
    chk("pred_ready", {31'b0, pred_ready}, {31'b0, rdy});
    chk("pred_tag", {30'b0, pred_tag}, (head_m + q.size()) % DEPTH);
    if (q.size() > 0) chk("resolve_ghr", {28'b0, resolve_ghr}, q[0]);
    chk("spec_ghr", {28'b0, spec_ghr}, spec_m);
    chk("commit_ghr", {28'b0, commit_ghr}, commit_m);
    chk("recovering", {31'b0, recovering}, {31'b0, rec_m});
`ifdef BP_HISTORY_CTRL_STATS_EN
    chk("stat_preds", {16'b0, stat_preds}, sp_m);
    chk("stat_mispreds", {16'b0, stat_mispreds}, sm_m);
`endif
    last_ready = pred_ready;
    last_tag   = int'(pred_tag);
    acc  = pv && rdy;
    fire = rv && (q.size() > 0);
    mis  = fire && rm;
    if (acc && sp_m < 65535) sp_m++;
    if (mis && sm_m < 65535) sm_m++;
    if (fire) commit_m = shf(commit_m, rt);
    if (mis || fl) begin
      spec_m = commit_m;
      q.delete();
      head_m = 0;
    end else begin
      if (fire) begin
        void'(q.pop_front());
        head_m = (head_m + 1) % DEPTH;
      end
      if (acc) begin
        q.push_back(spec_m);
        spec_m = shf(spec_m, pt);
      end
    end
    rec_m = !rec_m && (mis || fl);
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic mid_reset();
    #2;
    rst_ni = 0;
    #1;
    chk("rst_spec", {28'b0, spec_ghr}, 0);
    chk("rst_commit", {28'b0, commit_ghr}, 0);
    chk("rst_tag", {30'b0, pred_tag}, 0);
    chk("rst_ready", {31'b0, pred_ready}, 1);
    chk("rst_recovering", {31'b0, recovering}, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_ni = 1;
  endtask

  initial begin
    idle();
    model_reset();
    rst_ni = 0;
    #2;
    chk("reset_spec", {28'b0, spec_ghr}, 0);
    chk("reset_commit", {28'b0, commit_ghr}, 0);
    chk("reset_resolve_ghr", {28'b0, resolve_ghr}, 0);
    chk("reset_ready", {31'b0, pred_ready}, 1);
    @(posedge clk);
    #1;
    rst_ni = 1;

    // T, N, T after reset
    cycle(1, 1, 0, 0, 0, 0);
    chk("tnt_tag0", last_tag, 0);
    chk("tnt_spec0", {28'b0, spec_ghr}, 4'b0001);
    cycle(1, 0, 0, 0, 0, 0);
    chk("tnt_tag1", last_tag, 1);
    chk("tnt_spec1", {28'b0, spec_ghr}, 4'b0010);
    cycle(1, 1, 0, 0, 0, 0);
    chk("tnt_tag2", last_tag, 2);
    chk("tnt_spec2", {28'b0, spec_ghr}, 4'b0101);
    chk("tnt_resolve_ghr", {28'b0, resolve_ghr}, 0);

    // Full: ready low, stays low during the freeing resolve, high the cycle after
    cycle(1, 0, 0, 0, 0, 0);
    chk("full_ready", {31'b0, pred_ready}, 0);
    cycle(1, 1, 1, 1, 0, 0);
    chk("full_ready_on_resolve", {31'b0, last_ready}, 0);
    chk("full_ready_after", {31'b0, pred_ready}, 1);

    // Mispredict with 3 in flight, commit 0000
    mid_reset();
    repeat (3) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0);
    chk("misp_commit", {28'b0, commit_ghr}, 4'b0001);
    chk("misp_spec", {28'b0, spec_ghr}, 4'b0001);
    chk("misp_recovering", {31'b0, recovering}, 1);
    chk("misp_ready_n1", {31'b0, pred_ready}, 0);
    cycle(0, 0, 0, 0, 0, 0);
    chk("misp_ready_n2", {31'b0, pred_ready}, 1);
    chk("misp_tag_empty", {30'b0, pred_tag}, 0);

    // Simultaneous accept (T) and correct resolve (N) at count 2
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    chk("sim_commit", {28'b0, commit_ghr}, 4'b0010);
    chk("sim_spec", {28'b0, spec_ghr}, 4'b1101);
    chk("sim_resolve_ghr", {28'b0, resolve_ghr}, 4'b0011);
    chk("sim_tag", {30'b0, pred_tag}, 3);

    // Flush with commit 0110, spec 1011
    mid_reset();
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    chk("pre_flush_commit", {28'b0, commit_ghr}, 4'b0110);
    chk("pre_flush_spec", {28'b0, spec_ghr}, 4'b1011);
    cycle(0, 0, 0, 0, 0, 1);
    chk("flush_spec", {28'b0, spec_ghr}, 4'b0110);
    chk("flush_tag", {30'b0, pred_tag}, 0);
    chk("flush_recovering", {31'b0, recovering}, 1);
    cycle(0, 0, 1, 1, 0, 0);
    chk("recover_resolve_ignored", {28'b0, commit_ghr}, 4'b0110);

`ifdef BP_HISTORY_CTRL_STATS_EN
    mid_reset();
    repeat (3) cycle(1, 1, 0, 0, 0, 0);
    cycle(0, 0, 1, 0, 1, 0);
    cycle(0, 0, 0, 0, 0, 0);
    repeat (2) cycle(1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 1, 1, 0);
    chk("stat_preds_5", {16'b0, stat_preds}, 5);
    chk("stat_mispreds_2", {16'b0, stat_mispreds}, 2);
    cycle(0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0);
    while (sp_m < 65535) cycle(1, $urandom_range(0, 1) == 1, 1, $urandom_range(0, 1) == 1, 0, 0);
    cycle(1, 1, 1, 0, 0, 0);
    chk("stat_preds_sat", {16'b0, stat_preds}, 16'hFFFF);
`endif

    // Randomized traffic against the model
    mid_reset();
    for (int i = 0; i < 600; i++) begin
      bit rv;
      rv = $urandom_range(0, 99) < 45;
      cycle($urandom_range(0, 99) < 70, $urandom_range(0, 1) == 1, rv,
            $urandom_range(0, 1) == 1, rv && ($urandom_range(0, 99) < 20),
            $urandom_range(0, 99) < 4);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
